centroid_updater: RTL
=====================

// Module: centroid_updater
// PURPOSE
//  Consumes the one-hot closest-core result from the distance comparator, one point per beat.
//  Accumulates per-core coordinate sums and point counts over one K-means pass.
//  On finish, divides each enabled core's sums by its count, producing new centroids.
//  Streams the centroids back to the core register file through a valid/ready handshake.
// PARAMETERS
//  NCORE  16          number of cluster cores (matches the comparator's one-hot width)
//  CW     8           coordinate width, unsigned
//  CNTW   12          per-core point counter width (max 4095 points per core per pass)
//  SUMW   CW+CNTW     accumulator and divider width (derived, not overridden)
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       asynchronous, active-high reset
//  start          in   1       clear accumulators and open a pass (honoured in IDLE only)
//  en             in   NCORE   core enable mask, must be held stable for the whole pass
//  pointValid     in   1       point beat valid
//  pointReady     out  1       high only in ACCUM
//  pointX,pointY  in   CW      point coordinates
//  closestCore    in   NCORE   one-hot assignment for the current point
//  finish         in   1       end of pass, start centroid computation (honoured in ACCUM only)
//  centroidValid  out  1       centroid beat valid
//  centroidReady  in   1       downstream accepts the beat
//  centroidIdx    out  4       core index of the beat
//  centroidX,Y    out  CW      new centroid (floor of sum/count)
//  centroidEmpty  out  1       core received 0 points; X and Y are 0, so the caller keeps the old centroid
//  busy           out  1       state != IDLE
//  done           out  1       one-cycle pulse after the last beat
//  error          out  1       sticky error flag, cleared by start
// BEHAVIOUR
//  Reset: state=IDLE; all sums, counts and outputs = 0; pointReady=0.
//  FSM states: IDLE, ACCUM, SEL, DIV, EMIT, DONE.
//  IDLE -> ACCUM on start.
//  - start clears every sum, every count, error, and idx.
//  ACCUM, on each pointValid&&pointReady beat:
//  - closestCore one-hot at bit k, en[k]=1, count[k] < max: sumX[k]+=pointX, sumY[k]+=pointY, count[k]+=1.
//  - Any other case drops the point and sets error: closestCore zero or multi-hot, en[k]=0, or count[k] saturated.
//  - Sums cannot overflow (SUMW bits hold 4095*255).
//  ACCUM -> SEL on finish.
//  - A beat accepted in the same cycle as finish is still accumulated.
//  SEL, one cycle per core index idx:
//  - en[idx]=0: skip to idx+1, no beat.
//  - count=0: go to EMIT with centroidEmpty=1 and X=Y=0.
//  - Otherwise go to DIV.
//  DIV: two parallel restoring dividers (sumX/count, sumY/count), SUMW cycles, one quotient bit per cycle.
//  - Low CW quotient bits are kept; the quotient is always <= 2^CW-1.
//  EMIT: centroidValid held high with centroidIdx, X, Y and Empty stable until centroidReady.
//  - On the handshake: idx==NCORE-1 -> DONE, else idx+1 -> SEL.
//  - centroidValid must not drop or change data while ready is low.
//  DONE: done=1 for one cycle, then IDLE.
//  - If every core is disabled, no beats are sent and done still pulses.
//  Latency (finish in cycle 0, core 0 enabled and non-empty): SEL in cycle 1, DIV in cycles 2..SUMW+1, centroidValid from cycle SUMW+2.
//  Per enabled core: 1 + SUMW + (>=1) cycles; empty core: 2 cycles; disabled core: 1 cycle.
//  start outside IDLE and finish outside ACCUM are ignored; only rst aborts a pass.
//  rst asserted mid-pass clears everything immediately, with no partial beats and no done pulse.
//  Status outputs:
//  - pointReady and centroidValid are registered outputs.
//  - centroidEmpty is valid only while centroidValid=1.
//  - error stays high until the next start.
// TESTING
//  1. en=0x0003; core0 gets (10,20),(20,40),(31,61), core1 gets (255,255); finish
//     -> beats idx0 (20,40) Empty=0, idx1 (255,255); done; no error.
//  2. en=0x0005; core0 gets 4 points, core2 gets none -> idx0 beat, idx2 beat with Empty=1 and X=Y=0, idx1 never sent.
//  3. closestCore=0x0000, then 0x0006, then 0x0008 with en[3]=0 -> all three dropped, error=1, counts unchanged.
//  4. centroidReady low for 7 cycles during idx0 -> valid and data held stable; next beat only after the handshake.
//  5. 4096 beats to core0, all at (1,1) -> count saturates at 4095; last beat dropped, error=1; centroid (1,1).
//  6. rst pulsed during DIV of core1 -> all outputs 0 and IDLE next cycle; a fresh pass then yields correct results.

Source files
------------

// File: rtl/centroid_updater.sv
// -----------------------------------------------------------------------------
// centroid_updater
//   Accumulates per-core coordinate sums and point counts over one K-means
//   pass, then divides each enabled core's sums by its count and streams the
//   new centroids out over a valid/ready handshake.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   start                    clear accumulators and open a pass (IDLE only)
//   en[NCORE]                core enable mask, stable for the whole pass
//   pointValid / pointReady  point beat handshake (ready high only in ACCUM)
//   pointX, pointY           point coordinates
//   closestCore[NCORE]       one-hot core assignment of the current point
//   finish                   end of pass (ACCUM only)
//   centroidValid / Ready    centroid beat handshake
//   centroidIdx              core index of the beat
//   centroidX, centroidY     floor(sum / count)
//   centroidEmpty            core received no points (X = Y = 0)
//   busy, done, error        status: not idle, end-of-pass pulse, sticky error
// -----------------------------------------------------------------------------
module centroid_updater #(
    parameter int NCORE = 16,
    parameter int CW    = 8,
    parameter int CNTW  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NCORE-1:0] en,
    input  logic             pointValid,
    output logic             pointReady,
    input  logic [CW-1:0]    pointX,
    input  logic [CW-1:0]    pointY,
    input  logic [NCORE-1:0] closestCore,
    input  logic             finish,
    output logic             centroidValid,
    input  logic             centroidReady,
    output logic [3:0]       centroidIdx,
    output logic [CW-1:0]    centroidX,
    output logic [CW-1:0]    centroidY,
    output logic             centroidEmpty,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int SUMW = CW + CNTW;
    localparam int IW   = 4;
    localparam int STW  = $clog2(SUMW + 1);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NCORE - 1);
    localparam logic [STW-1:0] LAST_STEP = STW'(SUMW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_SEL   = 3'd2,
        S_DIV   = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    logic [SUMW-1:0]   r_sum_x [NCORE];
    logic [SUMW-1:0]   r_sum_y [NCORE];
    logic [CNTW-1:0]   r_cnt   [NCORE];
    logic [IW-1:0]     r_idx;
    logic [STW-1:0]    r_step;
    // Restoring divider state: r_dvd shifts the dividend out of its MSB and
    // collects quotient bits in its LSB, so it holds the quotient at the end.
    logic [SUMW:0]     r_rem_x;
    logic [SUMW:0]     r_rem_y;
    logic [SUMW-1:0]   r_dvd_x;
    logic [SUMW-1:0]   r_dvd_y;
    logic [SUMW-1:0]   r_den;
    logic              r_point_ready;
    logic              r_cent_valid;
    logic [IW-1:0]     r_cent_idx;
    logic [CW-1:0]     r_cent_x;
    logic [CW-1:0]     r_cent_y;
    logic              r_cent_empty;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_beat;
    logic              w_one_hot;
    logic [IW-1:0]     w_hit_idx;
    logic              w_cnt_sat;
    logic              w_keep;
    logic [SUMW:0]     w_trial_x;
    logic [SUMW:0]     w_trial_y;
    logic              w_qbit_x;
    logic              w_qbit_y;
    logic [SUMW:0]     w_rem_x_nx;
    logic [SUMW:0]     w_rem_y_nx;
    logic [SUMW-1:0]   w_dvd_x_nx;
    logic [SUMW-1:0]   w_dvd_y_nx;

    // Index of the highest set bit; only meaningful when the vector is one-hot.
    function automatic logic [IW-1:0] onehot_to_idx(input logic [NCORE-1:0] v);
        logic [IW-1:0] r;
        r = {IW{1'b0}};
        for (int i = 0; i < NCORE; i++) begin
            r = v[i] ? IW'(i) : r;
        end
        return r;
    endfunction

    // Point acceptance decode: which core is hit and whether the beat is kept.
    always_comb begin
        w_beat    = pointValid && r_point_ready;
        w_one_hot = (closestCore != {NCORE{1'b0}}) &&
                    ((closestCore & (closestCore - NCORE'(1))) == {NCORE{1'b0}});
        w_hit_idx = onehot_to_idx(closestCore);
        w_cnt_sat = (r_cnt[w_hit_idx] == {CNTW{1'b1}});
        w_keep    = w_one_hot && en[w_hit_idx] && !w_cnt_sat;
    end

    // One restoring-division step for X and Y sharing the same divisor.
    always_comb begin
        w_trial_x  = {r_rem_x[SUMW-1:0], r_dvd_x[SUMW-1]};
        w_trial_y  = {r_rem_y[SUMW-1:0], r_dvd_y[SUMW-1]};
        w_qbit_x   = (w_trial_x >= {1'b0, r_den});
        w_qbit_y   = (w_trial_y >= {1'b0, r_den});
        w_rem_x_nx = w_qbit_x ? (w_trial_x - {1'b0, r_den}) : w_trial_x;
        w_rem_y_nx = w_qbit_y ? (w_trial_y - {1'b0, r_den}) : w_trial_y;
        w_dvd_x_nx = {r_dvd_x[SUMW-2:0], w_qbit_x};
        w_dvd_y_nx = {r_dvd_y[SUMW-2:0], w_qbit_y};
    end

    // Pass controller: accumulation, per-core division and centroid emission.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            for (int i = 0; i < NCORE; i++) begin
                r_sum_x[i] <= {SUMW{1'b0}};
                r_sum_y[i] <= {SUMW{1'b0}};
                r_cnt[i]   <= {CNTW{1'b0}};
            end
            r_idx         <= {IW{1'b0}};
            r_step        <= {STW{1'b0}};
            r_rem_x       <= {(SUMW+1){1'b0}};
            r_rem_y       <= {(SUMW+1){1'b0}};
            r_dvd_x       <= {SUMW{1'b0}};
            r_dvd_y       <= {SUMW{1'b0}};
            r_den         <= {SUMW{1'b0}};
            r_point_ready <= 1'b0;
            r_cent_valid  <= 1'b0;
            r_cent_idx    <= {IW{1'b0}};
            r_cent_x      <= {CW{1'b0}};
            r_cent_y      <= {CW{1'b0}};
            r_cent_empty  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NCORE; i++) begin
                            r_sum_x[i] <= {SUMW{1'b0}};
                            r_sum_y[i] <= {SUMW{1'b0}};
                            r_cnt[i]   <= {CNTW{1'b0}};
                        end
                        r_idx         <= {IW{1'b0}};
                        r_error       <= 1'b0;
                        r_point_ready <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ACCUM;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCUM: begin
                    // A beat accepted together with finish is still counted.
                    if (w_beat) begin
                        if (w_keep) begin
                            r_sum_x[w_hit_idx] <= r_sum_x[w_hit_idx] + {{CNTW{1'b0}}, pointX};
                            r_sum_y[w_hit_idx] <= r_sum_y[w_hit_idx] + {{CNTW{1'b0}}, pointY};
                            r_cnt[w_hit_idx]   <= r_cnt[w_hit_idx] + {{(CNTW-1){1'b0}}, 1'b1};
                        end else begin
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_error <= r_error;
                    end
                    if (finish) begin
                        r_point_ready <= 1'b0;
                        r_state       <= S_SEL;
                    end else begin
                        r_state <= S_ACCUM;
                    end
                end
                S_SEL: begin
                    if (!en[r_idx]) begin
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + {{(IW-1){1'b0}}, 1'b1};
                            r_state <= S_SEL;
                        end
                    end else if (r_cnt[r_idx] == {CNTW{1'b0}}) begin
                        r_cent_valid <= 1'b1;
                        r_cent_idx   <= r_idx;
                        r_cent_x     <= {CW{1'b0}};
                        r_cent_y     <= {CW{1'b0}};
                        r_cent_empty <= 1'b1;
                        r_state      <= S_EMIT;
                    end else begin
                        r_rem_x <= {(SUMW+1){1'b0}};
                        r_rem_y <= {(SUMW+1){1'b0}};
                        r_dvd_x <= r_sum_x[r_idx];
                        r_dvd_y <= r_sum_y[r_idx];
                        r_den   <= {{CW{1'b0}}, r_cnt[r_idx]};
                        r_step  <= {STW{1'b0}};
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem_x <= w_rem_x_nx;
                    r_rem_y <= w_rem_y_nx;
                    r_dvd_x <= w_dvd_x_nx;
                    r_dvd_y <= w_dvd_y_nx;
                    r_step  <= r_step + {{(STW-1){1'b0}}, 1'b1};
                    // Mean of CW-bit values always fits in CW bits.
                    if (r_step == LAST_STEP) begin
                        r_cent_valid <= 1'b1;
                        r_cent_idx   <= r_idx;
                        r_cent_x     <= w_dvd_x_nx[CW-1:0];
                        r_cent_y     <= w_dvd_y_nx[CW-1:0];
                        r_cent_empty <= 1'b0;
                        r_state      <= S_EMIT;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_EMIT: begin
                    if (centroidReady) begin
                        r_cent_valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + {{(IW-1){1'b0}}, 1'b1};
                            r_state <= S_SEL;
                        end
                    end else begin
                        r_state <= S_EMIT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_point_ready <= 1'b0;
                    r_cent_valid  <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign pointReady    = r_point_ready;
    assign centroidValid = r_cent_valid;
    assign centroidIdx   = r_cent_idx;
    assign centroidX     = r_cent_x;
    assign centroidY     = r_cent_y;
    assign centroidEmpty = r_cent_empty;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;

endmodule
